// File: rtl/key_alu_accum_if.sv
// Pushbutton/operand inputs and result/status outputs of the key-driven ALU/accumulator.
// The master side drives keys and operands; the slave side is the ALU core.
interface key_alu_accum_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         key;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] result;
  logic [1:0]         mode;
  logic               carry;
  logic               zero;
  logic               busy;
  logic               done;

  modport master (
    output key, op_a, op_b,
    input  result, mode, carry, zero, busy, done
  );

  modport slave (
    input  key, op_a, op_b,
    output result, mode, carry, zero, busy, done
  );
endinterface

// File: rtl/key_alu_accum.sv
// Key-driven ALU/accumulator: synchronised active-low pushbuttons select and fire
// ADD / SUB / shift-add MUL / ACC into a 2*WIDTH result register.
//
// state     | meaning
// S_IDLE    | waiting for a key push; ADD/SUB/ACC complete here in one cycle
// S_MUL_RUN | one shift-add step per cycle, WIDTH steps, operands frozen
module key_alu_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  key_alu_accum_if.slave bus
);

  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;

  state_t state_q, state_d;

  logic [2:0]         k1_q, k2_q;
  logic [2:0]         push;
  logic               unused_key;

  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [1:0]         mode_q, mode_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] pp_q, pp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               busy;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   diff_w;
  logic [2*WIDTH:0]   acc_w;
  logic [2*WIDTH-1:0] step_pp;

  // KEY[3] has no function
  assign unused_key = bus.key[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k1_q <= 3'b111;
      k2_q <= 3'b111;
    end else begin
      k1_q <= bus.key[2:0];
      k2_q <= k1_q;
    end
  end

  // falling edge of the synchronised key: one pulse per press
  assign push = k2_q & ~k1_q;
  assign busy = (state_q == S_MUL_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (!busy) begin
      a_q <= bus.op_a;
      b_q <= bus.op_b;
    end
  end

  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w  = a_q - b_q;
  assign acc_w   = {1'b0, result_q} + {{(WIDTH+1){1'b0}}, a_q};
  assign step_pp = mplier_q[0] ? (pp_q + mcand_q) : pp_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    pp_d     = pp_q;
    cnt_d    = cnt_q;

    if (push[0]) begin
      state_d  = S_IDLE;
      result_d = '0;
      carry_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (push[1]) begin
            case (mode_q)
              2'd0: begin
                result_d = {{WIDTH{1'b0}}, sum_w[WIDTH-1:0]};
                carry_d  = sum_w[WIDTH];
                done_d   = 1'b1;
              end
              2'd1: begin
                result_d = {{WIDTH{1'b0}}, diff_w};
                carry_d  = (a_q < b_q);
                done_d   = 1'b1;
              end
              2'd2: begin
                state_d  = S_MUL_RUN;
                mcand_d  = {{WIDTH{1'b0}}, a_q};
                mplier_d = b_q;
                pp_d     = '0;
                cnt_d    = '0;
              end
              2'd3: begin
                {carry_d, result_d} = acc_w;
                done_d              = 1'b1;
              end
            endcase
          end else if (push[2]) begin
            mode_d = mode_q + 2'd1;
          end
        end
        S_MUL_RUN: begin
          pp_d     = step_pp;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            result_d = step_pp;
            carry_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      mode_q   <= 2'd0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      pp_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      pp_q     <= pp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.result = result_q;
  assign bus.mode   = mode_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = (result_q == '0);
  assign bus.busy   = busy;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_key_alu_accum.sv
// Bench for key_alu_accum: directed scenarios plus random key/operand traffic,
// all checked every cycle against a cycle-level behavioural model.
module tb_key_alu_accum;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_alu_accum_if #(.WIDTH(W)) bus();

  key_alu_accum #(.WIDTH(W), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  // behavioural model state (post-edge values)
  logic [3:0] m_s_prev = 4'hF;
  logic [3:0] m_s_cur  = 4'hF;
  logic [3:0] m_pr;
  int m_a = 0, m_b = 0;
  int m_result = 0, m_mode = 0, m_prod = 0, m_left = 0, m_s = 0;
  bit m_carry = 0, m_busy = 0, m_done = 0, m_was_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s_prev = 4'hF; m_s_cur = 4'hF;
      m_a = 0; m_b = 0; m_result = 0; m_mode = 0;
      m_carry = 0; m_busy = 0; m_done = 0; m_left = 0; m_prod = 0;
    end else begin
      m_pr = m_s_prev & ~m_s_cur;
      m_was_busy = m_busy;
      m_done = 0;
      if (m_pr[0]) begin
        m_result = 0; m_carry = 0; m_busy = 0; m_left = 0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_result = m_prod; m_carry = 0; m_done = 1; m_busy = 0;
        end
      end else if (m_pr[1]) begin
        case (m_mode)
          0: begin m_s = m_a + m_b; m_result = m_s % 256; m_carry = (m_s > 255); m_done = 1; end
          1: begin m_result = (m_a - m_b + 256) % 256; m_carry = (m_a < m_b); m_done = 1; end
          2: begin m_prod = m_a * m_b; m_left = W; m_busy = 1; end
          default: begin
            m_s = m_result + m_a; m_result = m_s % 65536; m_carry = (m_s > 65535); m_done = 1;
          end
        endcase
      end else if (m_pr[2]) begin
        m_mode = (m_mode + 1) % 4;
      end
      if (!m_was_busy) begin
        m_a = int'(bus.op_a);
        m_b = int'(bus.op_b);
      end
      m_s_prev = m_s_cur;
      m_s_cur  = bus.key;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("result", {16'h0, bus.result}, m_result);
      chk("mode",   {30'h0, bus.mode},   m_mode);
      chk("carry",  {31'h0, bus.carry},  {31'h0, m_carry});
      chk("zero",   {31'h0, bus.zero},   {31'h0, (m_result == 0)});
      chk("busy",   {31'h0, bus.busy},   {31'h0, m_busy});
      chk("done",   {31'h0, bus.done},   {31'h0, m_done});
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1) busy_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input int k);
    bus.key[k] = 1'b0;
    tick(3);
    bus.key[k] = 1'b1;
    tick(3);
  endtask

  task automatic set_ops(input int a, input int b);
    bus.op_a = W'(a);
    bus.op_b = W'(b);
    tick(2);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy === 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", bus.busy, budget);
    end
    tick(2);
  endtask

  initial begin
    bus.key  = 4'hF;
    bus.op_a = '0;
    bus.op_b = '0;
    tick(3);
    chk("rst_result", {16'h0, bus.result}, 32'h0);
    chk("rst_busy",   {31'h0, bus.busy},   32'h0);
    chk("rst_zero",   {31'h0, bus.zero},   32'h1);
    rst_n = 1'b1;
    tick(2);

    // T1: ADD with carry
    set_ops(200, 100);
    done_cnt = 0;
    press(1);
    chk("t1_result", {16'h0, bus.result}, 32'h002C);
    chk("t1_carry",  {31'h0, bus.carry},  32'h1);
    chk("t1_done",   done_cnt,            32'd1);
    chk("t1_model",  m_result,            32'h002C);

    // T2: SUB with and without borrow
    press(2);
    set_ops(5, 7);
    press(1);
    chk("t2_result_a", {16'h0, bus.result}, 32'h00FE);
    chk("t2_carry_a",  {31'h0, bus.carry},  32'h1);
    set_ops(7, 5);
    press(1);
    chk("t2_result_b", {16'h0, bus.result}, 32'h0002);
    chk("t2_carry_b",  {31'h0, bus.carry},  32'h0);

    // T3: MUL, operand change while busy
    press(2);
    set_ops(255, 255);
    done_cnt = 0;
    busy_cnt = 0;
    bus.key[1] = 1'b0;
    tick(3);
    bus.key[1] = 1'b1;
    bus.op_a = 8'h12;
    wait_idle(20);
    chk("t3_result", {16'h0, bus.result}, 32'hFE01);
    chk("t3_busy_cycles", busy_cnt, 32'd8);
    chk("t3_done", done_cnt, 32'd1);
    chk("t3_model", m_result, 32'hFE01);

    // T4: exec ignored while busy, then clear aborts the MUL
    set_ops(3, 5);
    done_cnt = 0;
    bus.key[1] = 1'b0;
    tick(3);
    bus.key[1] = 1'b1;
    tick(1);
    bus.key[1] = 1'b0;
    tick(2);
    bus.key[1] = 1'b1;
    bus.key[0] = 1'b0;
    tick(3);
    bus.key[0] = 1'b1;
    chk("t4_busy",   {31'h0, bus.busy},   32'h0);
    chk("t4_result", {16'h0, bus.result}, 32'h0);
    tick(12);
    chk("t4_done", done_cnt, 32'd0);

    // T5: preset 0xFFF0 then ACC overflow; mode wraps
    set_ops(255, 255);
    press(1);
    wait_idle(20);
    press(2);
    set_ops(8'hEF, 0); press(1);
    set_ops(8'hFF, 0); press(1);
    set_ops(8'h01, 0); press(1);
    chk("t5_preset", {16'h0, bus.result}, 32'hFFF0);
    set_ops(8'h20, 0); press(1);
    chk("t5_result", {16'h0, bus.result}, 32'h0010);
    chk("t5_carry",  {31'h0, bus.carry},  32'h1);
    chk("t5_model",  m_result,            32'h0010);
    repeat (4) press(2);
    chk("t5_mode", {30'h0, bus.mode}, 32'd3);

    // T6: held key, clear+exec together, reset mid-MUL
    done_cnt = 0;
    bus.key[1] = 1'b0;
    tick(50);
    bus.key[1] = 1'b1;
    tick(3);
    chk("t6_held_done", done_cnt, 32'd1);
    chk("t6_held_result", {16'h0, bus.result}, 32'h0030);
    done_cnt = 0;
    bus.key[1:0] = 2'b00;
    tick(3);
    bus.key[1:0] = 2'b11;
    tick(3);
    chk("t6_clr_result", {16'h0, bus.result}, 32'h0);
    chk("t6_clr_done", done_cnt, 32'd0);
    repeat (3) press(2);
    set_ops(9, 9);
    bus.key[1] = 1'b0;
    tick(3);
    bus.key[1] = 1'b1;
    chk("t6_mul_busy", {31'h0, bus.busy}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_result", {16'h0, bus.result}, 32'h0);
    chk("t6_rst_mode",   {30'h0, bus.mode},   32'h0);
    chk("t6_rst_carry",  {31'h0, bus.carry},  32'h0);
    chk("t6_rst_busy",   {31'h0, bus.busy},   32'h0);
    chk("t6_rst_done",   {31'h0, bus.done},   32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bus.key[0] = ($urandom_range(0, 39) != 0);
      bus.key[1] = ($urandom_range(0, 3) != 0);
      bus.key[2] = ($urandom_range(0, 3) != 0);
      bus.key[3] = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: bus.op_a = 8'hFF;
        1: bus.op_a = 8'h00;
        default: bus.op_a = W'($urandom);
      endcase
      bus.op_b = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      tick(1);
    end
    bus.key = 4'hF;
    tick(3);
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
